boot_loader_ctrl: RTL and testbench

- Boot sequencer for the rv32i single-cycle core. Accepts a word stream from a host over a valid/ready handshake.
- Writes the first `d_words` words into data BRAM and the next `i_words` words into instruction BRAM, at byte addresses index*4.
- Then releases the core: deasserts `pc_stall`, enables register/instruction reads, and hands the data BRAM write port to the CPU via `d_bram_init_done`.
- Replaces the hand-sequenced load loops used at bring-up and sits between the host interface and the fetch/memory stages.

---
 rtl/boot_loader_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: streams host words into data BRAM, then instruction BRAM, then releases the core.
// Optional end-of-load checksum word is enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  d_words,
    input  logic [CNT_WIDTH-1:0]  i_words,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic                  d_bram_init_done,
    output logic                  pc_stall,
    output logic                  rd_enbl,
    output logic                  i_r_enb,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef logic [IDX_W:0] cnt_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_D = 3'd1;
    localparam logic [2:0] ST_LOAD_I = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd4;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd5;
    localparam logic [2:0] ST_AFTER  = ST_CHECK;
`else
    localparam logic [2:0] ST_AFTER  = ST_RUN;
`endif

    function automatic cnt_t clamp(input logic [CNT_WIDTH-1:0] n);
        if (32'(n) > DEPTH) begin
            return cnt_t'(DEPTH);
        end
        return cnt_t'(n);
    endfunction

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    cnt_t                  d_cnt_q, d_cnt_d, i_cnt_q, i_cnt_d;
    // One-cycle hold after the final load word so its BRAM write lands before release.
    logic                  drain_q, drain_d;
    logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d, i_addr_q, i_addr_d;
    logic [DATA_WIDTH-1:0] d_dat_q, d_dat_d, i_dat_q, i_dat_d;
    logic                  d_enb_q, d_enb_d, i_enb_q, i_enb_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
`endif

    logic in_load, xfer, last, take_start;
    cnt_t cur_cnt;

    always_comb begin
        in_load = (state_q == ST_LOAD_D) || (state_q == ST_LOAD_I);
`ifdef BOOT_LOADER_CHECKSUM_EN
        s_ready = (in_load && !drain_q) || (state_q == ST_CHECK);
`else
        s_ready = in_load && !drain_q;
`endif
        xfer    = s_valid && s_ready;
        cur_cnt = (state_q == ST_LOAD_D) ? d_cnt_q : i_cnt_q;
        last    = (cnt_t'(idx_q) + cnt_t'(1)) == cur_cnt;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        d_cnt_d    = d_cnt_q;
        i_cnt_d    = i_cnt_q;
        drain_d    = 1'b0;
        d_addr_d   = d_addr_q;
        i_addr_d   = i_addr_q;
        d_dat_d    = d_dat_q;
        i_dat_d    = i_dat_q;
        d_enb_d    = 1'b0;
        i_enb_d    = 1'b0;
        take_start = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_RUN: take_start = start;
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_ERROR: take_start = start;
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (32'(s_data) == sum_q) ? ST_RUN : ST_ERROR;
                end
            end
`endif
            ST_LOAD_D, ST_LOAD_I: begin
                if (drain_q) begin
                    state_d = ST_AFTER;
                end else if (xfer) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    sum_d = sum_q + 32'(s_data);
`endif
                    if (state_q == ST_LOAD_D) begin
                        d_addr_d = {idx_q, 2'b00};
                        d_dat_d  = s_data;
                        d_enb_d  = 1'b1;
                    end else begin
                        i_addr_d = {idx_q, 2'b00};
                        i_dat_d  = s_data;
                        i_enb_d  = 1'b1;
                    end
                    if (last) begin
                        idx_d = '0;
                        if (state_q == ST_LOAD_D && i_cnt_q != '0) begin
                            state_d = ST_LOAD_I;
                        end else begin
                            drain_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_start) begin
            d_cnt_d = clamp(d_words);
            i_cnt_d = clamp(i_words);
            idx_d   = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            if (d_words != '0) begin
                state_d = ST_LOAD_D;
            end else if (i_words != '0) begin
                state_d = ST_LOAD_I;
            end else begin
                state_d = ST_AFTER;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            d_cnt_q  <= '0;
            i_cnt_q  <= '0;
            drain_q  <= 1'b0;
            d_addr_q <= '0;
            i_addr_q <= '0;
            d_dat_q  <= '0;
            i_dat_q  <= '0;
            d_enb_q  <= 1'b0;
            i_enb_q  <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            d_cnt_q  <= d_cnt_d;
            i_cnt_q  <= i_cnt_d;
            drain_q  <= drain_d;
            d_addr_q <= d_addr_d;
            i_addr_q <= i_addr_d;
            d_dat_q  <= d_dat_d;
            i_dat_q  <= i_dat_d;
            d_enb_q  <= d_enb_d;
            i_enb_q  <= i_enb_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign d_w_addr         = d_addr_q;
    assign d_w_dat          = d_dat_q;
    assign d_w_enb          = d_enb_q;
    assign i_w_addr         = i_addr_q;
    assign i_w_dat          = i_dat_q;
    assign i_w_enb          = i_enb_q;
    assign done             = (state_q == ST_RUN);
    assign pc_stall         = !done;
    assign rd_enbl          = done;
    assign i_r_enb          = done;
    assign d_bram_init_done = done;
`ifdef BOOT_LOADER_CHECKSUM_EN
    assign busy             = in_load || (state_q == ST_CHECK);
    assign error            = (state_q == ST_ERROR);
`else
    assign busy             = in_load;
    assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl; the checksum section runs when BOOT_LOADER_CHECKSUM_EN is defined.
module tb_boot_loader_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] d_words, i_words;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [AW-1:0] d_w_addr, i_w_addr;
    logic [DW-1:0] d_w_dat, i_w_dat;
    logic          d_w_enb, i_w_enb;
    logic          d_bram_init_done, pc_stall, rd_enbl, i_r_enb, busy, done, error;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sum;

    boot_loader_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .d_words(d_words), .i_words(i_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall), .rd_enbl(rd_enbl),
        .i_r_enb(i_r_enb), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after the final load word's edge; returns with the core in RUN.
    task automatic after_load(input logic [31:0] cks);
        s_valid = 1'b0;
        s_data  = cks;
`ifdef BOOT_LOADER_CHECKSUM_EN
        tick();
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
`else
        tick();
`endif
    endtask

    task automatic go(input int dw, input int iw);
        d_words = CW'(dw);
        i_words = CW'(iw);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        sum     = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; d_words = '0; i_words = '0; s_valid = 1'b0; s_data = '0;
        tick();
        tick();
        chk("rst_pc_stall", pc_stall, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_init_done", d_bram_init_done, 0);
        chk("rst_rd_enbl", rd_enbl, 0);
        chk("rst_d_w_enb", d_w_enb, 0);
        chk("rst_d_w_addr", 32'(d_w_addr), 0);
        rst = 1'b0;
        tick();

        // Back-to-back load, 3 data + 7 instruction words
        go(3, 7);
        chk("b2b_busy", busy, 1);
        chk("b2b_s_ready", s_ready, 1);
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = 32'hA000 + 32'(k);
            sum    = sum + s_data;
            tick();
            chk("b2b_d_enb", d_w_enb, 1);
            chk("b2b_d_addr", 32'(d_w_addr), 32'(k * 4));
            chk("b2b_d_dat", d_w_dat, 32'hA000 + 32'(k));
        end
        for (int k = 0; k < 7; k++) begin
            s_data = 32'hB000 + 32'(k);
            sum    = sum + s_data;
            tick();
            chk("b2b_i_enb", i_w_enb, 1);
            chk("b2b_i_addr", 32'(i_w_addr), 32'(k * 4));
            chk("b2b_i_dat", i_w_dat, 32'hB000 + 32'(k));
            chk("b2b_no_d_enb", d_w_enb, 0);
        end
        chk("b2b_stall_last", pc_stall, 1);
        after_load(sum);
        chk("b2b_i_enb_off", i_w_enb, 0);
        chk("b2b_pc_stall", pc_stall, 0);
        chk("b2b_done", done, 1);
        chk("b2b_rd_enbl", rd_enbl, 1);
        chk("b2b_i_r_enb", i_r_enb, 1);
        chk("b2b_init_done", d_bram_init_done, 1);
        chk("b2b_busy_off", busy, 0);

        // Restart from RUN with zero data count
        go(0, 2);
        chk("rs_pc_stall", pc_stall, 1);
        chk("rs_init_done", d_bram_init_done, 0);
        chk("rs_done", done, 0);
        chk("rs_rd_enbl", rd_enbl, 0);
        chk("rs_busy", busy, 1);
        s_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_data = 32'hC000 + 32'(k);
            sum    = sum + s_data;
            tick();
            chk("z_i_enb", i_w_enb, 1);
            chk("z_i_addr", 32'(i_w_addr), 32'(k * 4));
            chk("z_no_d_enb", d_w_enb, 0);
        end
        after_load(sum);
        chk("z_done", done, 1);

        // Host gaps during data load
        go(2, 1);
        s_valid = 1'b1; s_data = 32'h11; sum = sum + s_data;
        tick();
        chk("gap_enb0", d_w_enb, 1);
        chk("gap_addr0", 32'(d_w_addr), 0);
        s_valid = 1'b0;
        tick();
        chk("gap_idle1", d_w_enb, 0);
        tick();
        chk("gap_idle2", d_w_enb, 0);
        chk("gap_busy", busy, 1);
        s_valid = 1'b1; s_data = 32'h22; sum = sum + s_data;
        tick();
        chk("gap_enb1", d_w_enb, 1);
        chk("gap_addr1", 32'(d_w_addr), 4);
        chk("gap_dat1", d_w_dat, 32'h22);
        s_data = 32'h33; sum = sum + s_data;
        tick();
        chk("gap_i_enb", i_w_enb, 1);
        chk("gap_i_addr", 32'(i_w_addr), 0);
        after_load(sum);
        chk("gap_done", done, 1);

        // Reset after 2 of 5 instruction words
        go(0, 5);
        s_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_data = 32'hD000 + 32'(k);
            tick();
        end
        s_data = 32'hD002;
        rst = 1'b1;
        #1;
        chk("mr_i_enb", i_w_enb, 0);
        chk("mr_i_addr", 32'(i_w_addr), 0);
        chk("mr_i_dat", i_w_dat, 0);
        chk("mr_pc_stall", pc_stall, 1);
        chk("mr_s_ready", s_ready, 0);
        chk("mr_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("mr_no_write", i_w_enb, 0);
        chk("mr_idle_ready", s_ready, 0);
        s_valid = 1'b0;
        go(1, 1);
        s_valid = 1'b1; s_data = 32'hE0; sum = sum + s_data;
        tick();
        chk("mr_re_d_enb", d_w_enb, 1);
        chk("mr_re_d_addr", 32'(d_w_addr), 0);
        s_data = 32'hE1; sum = sum + s_data;
        tick();
        chk("mr_re_i_enb", i_w_enb, 1);
        chk("mr_re_i_addr", 32'(i_w_addr), 0);
        after_load(sum);
        chk("mr_re_done", done, 1);

        // Data count above depth clamps to 256 words
        go(300, 1);
        s_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            s_data = 32'(k);
            sum    = sum + s_data;
            tick();
            if (k == 255) begin
                chk("cl_d_enb", d_w_enb, 1);
                chk("cl_d_addr", 32'(d_w_addr), 32'h3FC);
            end
        end
        s_data = 32'h5A; sum = sum + s_data;
        tick();
        chk("cl_i_enb", i_w_enb, 1);
        chk("cl_i_addr", 32'(i_w_addr), 0);
        chk("cl_no_d_enb", d_w_enb, 0);
        after_load(sum);
        chk("cl_done", done, 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Good and bad checksum after words 1,2,3
        for (int pass = 0; pass < 2; pass++) begin
            go(2, 1);
            s_valid = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                s_data = 32'(k);
                tick();
            end
            s_valid = 1'b0;
            tick();
            chk("ck_s_ready", s_ready, 1);
            chk("ck_busy", busy, 1);
            s_valid = 1'b1;
            s_data  = (pass == 0) ? 32'd6 : 32'd7;
            tick();
            s_valid = 1'b0;
            chk("ck_done", done, (pass == 0) ? 1 : 0);
            chk("ck_error", error, (pass == 0) ? 0 : 1);
            chk("ck_pc_stall", pc_stall, (pass == 0) ? 0 : 1);
            chk("ck_busy_off", busy, 0);
        end
        go(0, 0);
        chk("ck_err_cleared", error, 0);
        chk("ck_check_ready", s_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
